vec_mem_seq: RTL and testbench

Parametrised vector memory sequencer for the CVP14 vector datapath. It takes over multi-cycle VLD/VST traffic from the core FSM. On a single start pulse it moves up to LANES elements of WIDTH bits between a packed vector register image and the scalar-wide memory bus, one element per accepted bus cycle. It adds over the fixed 16×16-bit unit-stride scheme:
- programmable lane count;
- signed stride;
- memory wait-state handshake.

---
 rtl/vec_mem_seq.sv | 148 ++++++++++++++
 tb/tb_vec_mem_seq.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vec_mem_seq.sv
// Vector memory sequencer: moves up to LANES elements between a packed vector image and the scalar memory bus (VLD/VST); optional signed stride under VMS_STRIDE_EN.
// Latency: start at edge 0, request in cycle 1; done in cycle N+2 (load) or N+1 (store), or cycle 1 when N=0; one more cycle per stalled request.
// Backpressure: mem_ready=0 holds Addr/RD/WR/dataOut stable and the lane index frozen; start is ignored while busy.
module vec_mem_seq #(
    parameter int LANES  = 16,
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 16
) (
    input  logic                       Clk1,
    input  logic                       Reset,
    input  logic                       start,
    input  logic                       is_store,
    input  logic [ADDR_W-1:0]          base_addr,
    input  logic [ADDR_W-1:0]          stride,
    input  logic [$clog2(LANES+1)-1:0] count,
    input  logic [LANES*WIDTH-1:0]     wr_vec,
    output logic [LANES*WIDTH-1:0]     rd_vec,
    output logic                       busy,
    output logic                       done,
    output logic [ADDR_W-1:0]          Addr,
    output logic                       RD,
    output logic                       WR,
    output logic [WIDTH-1:0]           dataOut,
    input  logic [WIDTH-1:0]           DataIn,
    input  logic                       mem_ready
);

    localparam int CW = $clog2(LANES+1);
    localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [CW-1:0] LANES_C = CW'(LANES);
    localparam logic [CW-1:0] ONE_C   = CW'(1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

    state_t            state_q, state_d;
    logic              store_q;
    logic [CW-1:0]     n_q;
    logic [CW-1:0]     lane_q;
    logic [ADDR_W-1:0] addr_q;
    logic [WIDTH-1:0]  wr_lanes [LANES];
    logic [WIDTH-1:0]  rd_lanes [LANES];
    logic              cap_vld_q;
    logic [LW-1:0]     cap_lane_q;

    logic [CW-1:0]     n_eff;
    logic              start_acc;
    logic              accept;
    logic              last_lane;
    logic [LW-1:0]     lane_idx;
    logic [ADDR_W-1:0] step;

    assign n_eff     = (count > LANES_C) ? LANES_C : count;
    assign start_acc = start && (state_q == S_IDLE);
    assign accept    = (state_q == S_ISSUE) && mem_ready;
    assign last_lane = ((lane_q + ONE_C) == n_q);
    assign lane_idx  = lane_q[LW-1:0];

`ifdef VMS_STRIDE_EN
    logic [ADDR_W-1:0] stride_q;

    // Latch the signed stride; the address accumulator adds it per accepted lane.
    always_ff @(posedge Clk1 or negedge Reset) begin
        if (!Reset)
            stride_q <= '0;
        else if (start_acc)
            stride_q <= stride;
    end

    assign step = stride_q;
`else
    logic unused_stride;
    assign unused_stride = ^stride;
    assign step          = ADDR_W'(1);
`endif

    // Request outputs decode straight from state, so an async reset drops them at once.
    assign busy    = (state_q != S_IDLE);
    assign done    = (state_q == S_DONE);
    assign RD      = (state_q == S_ISSUE) && !store_q;
    assign WR      = (state_q == S_ISSUE) && store_q;
    assign dataOut = WR ? wr_lanes[lane_idx] : '0;
    assign Addr    = addr_q;

    // State register.
    always_ff @(posedge Clk1 or negedge Reset) begin
        if (!Reset)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    // Next-state logic: a load needs one extra DRAIN cycle to catch the last read beat.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = (n_eff == '0) ? S_DONE : S_ISSUE;
            S_ISSUE: if (accept && last_lane) state_d = store_q ? S_DONE : S_DRAIN;
            S_DRAIN: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Command latch, lane counter and address accumulator; everything advances only on acceptance.
    always_ff @(posedge Clk1 or negedge Reset) begin
        if (!Reset) begin
            store_q    <= 1'b0;
            n_q        <= '0;
            lane_q     <= '0;
            addr_q     <= '0;
            cap_vld_q  <= 1'b0;
            cap_lane_q <= '0;
            for (int i = 0; i < LANES; i++) wr_lanes[i] <= '0;
        end else begin
            if (start_acc) begin
                store_q <= is_store;
                n_q     <= n_eff;
                lane_q  <= '0;
                addr_q  <= base_addr;
                for (int i = 0; i < LANES; i++) wr_lanes[i] <= wr_vec[i*WIDTH +: WIDTH];
            end else if (accept) begin
                lane_q <= lane_q + ONE_C;
                addr_q <= addr_q + step;
            end
            cap_vld_q  <= accept && !store_q;
            cap_lane_q <= lane_idx;
        end
    end

    // Load result image: unused lanes cleared at load start, read data lands one cycle after acceptance.
    always_ff @(posedge Clk1 or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < LANES; i++) rd_lanes[i] <= '0;
        end else begin
            if (start_acc && !is_store) begin
                for (int i = 0; i < LANES; i++)
                    if (i >= int'(n_eff)) rd_lanes[i] <= '0;
            end
            if (cap_vld_q)
                rd_lanes[cap_lane_q] <= DataIn;
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_pack
        assign rd_vec[g*WIDTH +: WIDTH] = rd_lanes[g];
    end

endmodule

// File: tb/tb_vec_mem_seq.sv
// Testbench for vec_mem_seq: directed and random VLD/VST traffic against a lane-level reference model.
// Expected bus accesses and completions are queued at issue time and consumed by an independent monitor.
// The memory model returns 0xA000+addr one cycle after each accepted read and drives mem_ready per test mode.
module tb_vec_mem_seq;

    localparam int LANES  = 16;
    localparam int WIDTH  = 16;
    localparam int ADDR_W = 16;
    localparam int CW     = 5;

    logic                   Clk1      = 1'b0;
    logic                   Reset     = 1'b0;
    logic                   start     = 1'b0;
    logic                   is_store  = 1'b0;
    logic [ADDR_W-1:0]      base_addr = '0;
    logic [ADDR_W-1:0]      stride    = '0;
    logic [CW-1:0]          count     = '0;
    logic [LANES*WIDTH-1:0] wr_vec    = '0;
    logic [LANES*WIDTH-1:0] rd_vec;
    logic                   busy;
    logic                   done;
    logic [ADDR_W-1:0]      Addr;
    logic                   RD;
    logic                   WR;
    logic [WIDTH-1:0]       dataOut;
    logic [WIDTH-1:0]       DataIn    = '0;
    logic                   mem_ready = 1'b0;

    vec_mem_seq #(.LANES(LANES), .WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
        .Clk1(Clk1), .Reset(Reset), .start(start), .is_store(is_store),
        .base_addr(base_addr), .stride(stride), .count(count), .wr_vec(wr_vec),
        .rd_vec(rd_vec), .busy(busy), .done(done), .Addr(Addr), .RD(RD), .WR(WR),
        .dataOut(dataOut), .DataIn(DataIn), .mem_ready(mem_ready)
    );

    always #5 Clk1 = ~Clk1;

    int cyc = 0;
    always @(posedge Clk1) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [LANES*WIDTH-1:0] rv;
        int                     due;
    } done_t;

    logic [33:0]            bq[$];
    done_t                  dq[$];
    logic [LANES*WIDTH-1:0] model_rd = '0;
    int                     ready_mode = 0;
    int                     s_cur = 0;

    task automatic check(input string name, input logic [299:0] act, input logic [299:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name, input string act, input string req);
        checks++;
        failures++;
        $display("FAIL %s actual=%s required=%s", name, act, req);
    endtask

    function automatic logic [15:0] mem_fn(input logic [15:0] a);
        return 16'hA000 + a;
    endfunction

    // Memory model: read data for an accepted request appears in the following cycle.
    initial begin
        logic        pend;
        logic [15:0] a;
        forever begin
            @(negedge Clk1);
            pend = RD && mem_ready;
            a    = Addr;
            @(posedge Clk1);
            #1;
            DataIn = pend ? mem_fn(a) : 16'($urandom);
            case (ready_mode)
                0:       mem_ready = 1'b1;
                1:       mem_ready = ($urandom_range(0, 3) != 0);
                default: mem_ready = !(((cyc - s_cur) == 2) || ((cyc - s_cur) == 3));
            endcase
        end
    end

    // Monitor: consumes expected accesses and completions as the DUT presents them.
    initial begin
        int          stalls;
        logic        prev_stall;
        logic [33:0] prev_bus;
        logic [33:0] cur_bus;
        done_t       e;
        stalls     = 0;
        prev_stall = 1'b0;
        prev_bus   = '0;
        forever begin
            @(negedge Clk1);
            if (Reset) begin
                cur_bus = {RD, WR, Addr, dataOut};
                check("bus_excl", {RD & WR, !WR && (dataOut != '0)}, 2'b00);
                if (prev_stall && (RD || WR))
                    check("stall_hold", cur_bus, prev_bus);
                if ((RD || WR) && mem_ready) begin
                    if (bq.size() == 0) fail_now("bus_unexpected", $sformatf("%0h", cur_bus), "no_access");
                    else check("bus_access", cur_bus, bq.pop_front());
                end
                if ((RD || WR) && !mem_ready) stalls++;
                prev_stall = (RD || WR) && !mem_ready;
                prev_bus   = cur_bus;
                if (done) begin
                    if (dq.size() == 0) begin
                        fail_now("done_unexpected", "done=1", "done=0");
                    end else begin
                        e = dq.pop_front();
                        check("done_cycle", cyc, e.due + stalls);
                        check("rd_vec", rd_vec, e.rv);
                    end
                    stalls = 0;
                end
            end else begin
                stalls     = 0;
                prev_stall = 1'b0;
            end
        end
    end

    task automatic finish_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    endtask

    task automatic wait_idle();
        int k;
        for (k = 0; k < 500; k++) begin
            if (!busy && bq.size() == 0 && dq.size() == 0) break;
            @(posedge Clk1);
            #1;
        end
        if (k == 500) begin
            fail_now("timeout", $sformatf("busy=%0d bq=%0d dq=%0d", busy, bq.size(), dq.size()), "idle");
            finish_run();
        end
    endtask

    // Issue one command and queue what the memory bus and completion must show.
    task automatic issue(input bit st, input logic [15:0] b, input logic [15:0] s,
                         input int cnt, input logic [LANES*WIDTH-1:0] wv, input int rm);
        int                     n;
        int                     lat;
        logic [15:0]            es;
        logic [15:0]            a;
        logic [LANES*WIDTH-1:0] nrv;
        done_t                  e;
        wait_idle();
        @(posedge Clk1);
        #1;
        is_store   = st;
        base_addr  = b;
        stride     = s;
        count      = cnt[4:0];
        wr_vec     = wv;
        ready_mode = rm;
        s_cur      = cyc;
        start      = 1'b1;
        n = (cnt > LANES) ? LANES : cnt;
`ifdef VMS_STRIDE_EN
        es = s;
`else
        es = 16'd1;
`endif
        nrv = st ? model_rd : '0;
        for (int i = 0; i < n; i++) begin
            a = b + 16'(i) * es;
            if (!st) nrv[i*WIDTH +: WIDTH] = mem_fn(a);
            bq.push_back({!st, st, a, st ? wv[i*WIDTH +: WIDTH] : 16'h0});
        end
        lat      = (n == 0) ? 1 : (st ? n + 1 : n + 2);
        e.rv     = nrv;
        e.due    = s_cur + lat;
        dq.push_back(e);
        model_rd = nrv;
        @(posedge Clk1);
        #1;
        start     = 1'b0;
        is_store  = 1'($urandom);
        base_addr = 16'($urandom);
        stride    = 16'($urandom);
        count     = 5'($urandom);
        wr_vec    = {8{32'($urandom)}};
    endtask

    initial begin
        logic [LANES*WIDTH-1:0] v;
        repeat (3) @(posedge Clk1);
        #3;
        Reset = 1'b1;
        @(posedge Clk1);
        #1;
        check("reset_addr", Addr, 0);
        check("reset_rd", RD, 0);
        check("reset_wr", WR, 0);
        check("reset_dout", dataOut, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_rdvec", rd_vec, 0);

        // Unit-stride 16-lane load.
        issue(1'b0, 16'h0100, 16'h0001, 16, '0, 0);

        // Negative stride wrapping below zero.
        v = '0;
        for (int i = 0; i < 4; i++) v[i*WIDTH +: WIDTH] = 16'h1111 * 16'(i + 1);
        issue(1'b1, 16'h0002, 16'hFFFF, 4, v, 0);

        // Partial load with wait states in cycles 2-3.
        issue(1'b0, 16'h0200, 16'h0001, 3, '0, 2);

        // Zero count, load and store.
        issue(1'b0, 16'h0300, 16'h0001, 0, '0, 0);
        issue(1'b1, 16'h0300, 16'h0001, 0, {8{32'hDEADBEEF}}, 0);

        // Over-range count clamps to LANES.
        issue(1'b0, 16'h0400, 16'h0002, 20, '0, 0);

        // Start while busy is ignored.
        issue(1'b1, 16'h0500, 16'h0003, 8, {8{32'($urandom)}}, 0);
        repeat (2) @(posedge Clk1);
        #1;
        start     = 1'b1;
        is_store  = 1'b0;
        base_addr = 16'h7777;
        count     = 5'd2;
        @(posedge Clk1);
        #1;
        start = 1'b0;

        // Stride ignored when the feature is compiled out.
        issue(1'b0, 16'h0010, 16'h0004, 3, '0, 0);

        // Randomised traffic with random wait states.
        for (int t = 0; t < 30; t++)
            issue(1'($urandom), 16'($urandom), 16'($urandom_range(0, 7)) - 16'd3,
                  $urandom_range(0, 20), {8{32'($urandom)}}, 1);

        // Reset in cycle 5 of a 16-lane load.
        issue(1'b0, 16'h0800, 16'h0001, 16, '0, 0);
        repeat (4) @(posedge Clk1);
        #2;
        Reset = 1'b0;
        #1;
        check("midreset_rd", RD, 0);
        check("midreset_busy", busy, 0);
        check("midreset_rdvec", rd_vec, 0);
        bq.delete();
        dq.delete();
        model_rd = '0;
        repeat (2) @(posedge Clk1);
        #3;
        Reset = 1'b1;
        issue(1'b0, 16'h0900, 16'h0001, 16, '0, 1);

        wait_idle();
        repeat (3) @(posedge Clk1);
        #1;
        check("bq_empty", bq.size(), 0);
        check("dq_empty", dq.size(), 0);
        finish_run();
    end

endmodule
